axi_cache_bridge: RTL and testbench

AXI4 master bridge between the core's instruction and data caches and the 64-bit AXI4 memory slave. It arbitrates between an I-side read port and a D-side read/write port, turns each granted request into a single AXI transaction, and returns data beats to the owner. Line transfers are INCR bursts; uncached accesses are single beats. Only one transaction is outstanding at a time.

---
 rtl/axi_cache_bridge_if.sv | 71 +++++++
 rtl/axi_cache_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi_cache_bridge.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_cache_bridge_if.sv
// AXI4 bus bundle between the cache bridge (master) and the memory slave.
// It carries all five channels plus the constant lock/cache/prot sideband fields.
interface axi_cache_bridge_if;
  // Read address channel
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // Write address channel
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [3:0]  wid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_cache_bridge.sv
// AXI4 master bridge for the I- and D-caches. It arbitrates round-robin
// between the two clients and runs one transaction at a time: an INCR line
// burst or a single beat. Read beats are forwarded to the owner in the same
// cycle they arrive. Grants are combinational in IDLE, so a client sees its
// ack in the cycle its request is first sampled.
module axi_cache_bridge #(
  parameter int         LINE_BEATS = 4,
  parameter logic [3:0] ID_I       = 4'd0,
  parameter logic [3:0] ID_D       = 4'd1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  // I-side client
  input  logic                     i_req,
  input  logic                     i_burst,
  input  logic [31:0]              i_addr,
  output logic                     i_ack,
  output logic                     i_rvalid,
  output logic [63:0]              i_rdata,
  output logic                     i_rlast,
  // D-side client
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic                     d_burst,
  input  logic [31:0]              d_addr,
  input  logic [64*LINE_BEATS-1:0] d_wline,
  input  logic [7:0]               d_wstrb,
  output logic                     d_ack,
  output logic                     d_rvalid,
  output logic [63:0]              d_rdata,
  output logic                     d_rlast,
  output logic                     d_wdone,
  output logic                     bus_err,
  // AXI4 memory bus
  axi_cache_bridge_if.master       axi
);

  localparam int         IDXW     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [7:0] LEN_LINE = 8'(LINE_BEATS - 1);
  localparam logic [3:0] CNT_LINE = 4'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic                           r_last_d;   // 1: D was granted last
  logic                           r_owner_d;  // 1: current transaction belongs to D
  logic [31:0]                    r_addr;
  logic                           r_burst;
  logic [LINE_BEATS-1:0][63:0]    r_wline;
  logic [7:0]                     r_wstrb;
  logic [3:0]                     r_cnt;
  logic                           r_wsent;    // every write beat already accepted

  logic                           w_grant_i;
  logic                           w_grant_d;
  logic [7:0]                     w_len;
  logic [3:0]                     w_cnt_len;
  logic                           w_cnt_last;
  logic                           w_wbeat_hs;
  logic [3:0]                     w_id;
  logic                           w_r_i;
  logic                           w_r_d;
  logic                           w_unused;

  assign w_len      = r_burst ? LEN_LINE : 8'd0;
  assign w_cnt_len  = r_burst ? CNT_LINE : 4'd0;
  assign w_cnt_last = (r_cnt == w_cnt_len);
  assign w_wbeat_hs = axi.wvalid & axi.wready;
  assign w_id       = r_owner_d ? ID_D : ID_I;

  // Arbitration and next-state selection for the transaction FSM
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req && d_req) begin
          if (r_last_d) begin
            w_grant_i = 1'b1;
          end else begin
            w_grant_d = 1'b1;
          end
        end else if (i_req) begin
          w_grant_i = 1'b1;
        end else if (d_req) begin
          w_grant_d = 1'b1;
        end else begin
          w_grant_i = 1'b0;
        end
        if (w_grant_i) begin
          w_next = S_AR;
        end else if (w_grant_d) begin
          w_next = d_we ? S_AW : S_AR;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_AR: begin
        if (axi.arready) begin
          w_next = S_R;
        end else begin
          w_next = S_AR;
        end
      end
      S_R: begin
        if (axi.rvalid && axi.rlast) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_R;
        end
      end
      S_AW: begin
        if (axi.awready) begin
          if (r_wsent || (w_wbeat_hs && w_cnt_last)) begin
            w_next = S_B;
          end else begin
            w_next = S_W;
          end
        end else begin
          w_next = S_AW;
        end
      end
      S_W: begin
        if (w_wbeat_hs && w_cnt_last) begin
          w_next = S_B;
        end else begin
          w_next = S_W;
        end
      end
      S_B: begin
        if (axi.bvalid) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_B;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the granted request and remember which side won for round-robin
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_last_d  <= 1'b0;
      r_owner_d <= 1'b0;
      r_addr    <= 32'd0;
      r_burst   <= 1'b0;
      r_wline   <= '0;
      r_wstrb   <= 8'd0;
    end else if (w_grant_i) begin
      r_last_d  <= 1'b0;
      r_owner_d <= 1'b0;
      r_addr    <= i_addr;
      r_burst   <= i_burst;
    end else if (w_grant_d) begin
      r_last_d  <= 1'b1;
      r_owner_d <= 1'b1;
      r_addr    <= d_addr;
      r_burst   <= d_burst;
      r_wline   <= d_wline;
      r_wstrb   <= d_wstrb;
    end
  end

  // Write beat counter; saturates at len and flags completion instead of wrapping
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt   <= 4'd0;
      r_wsent <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_cnt   <= 4'd0;
      r_wsent <= 1'b0;
    end else if (w_wbeat_hs) begin
      if (w_cnt_last) begin
        r_wsent <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Read address channel: fields come from the latched request, so they stay stable
  assign axi.arvalid = (r_state == S_AR);
  assign axi.araddr  = r_addr;
  assign axi.arid    = w_id;
  assign axi.arlen   = w_len;
  assign axi.arsize  = 3'd3;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.rready  = (r_state == S_R);

  // Write channels: beat 0 is offered together with the address
  assign axi.awvalid = (r_state == S_AW);
  assign axi.awaddr  = r_addr;
  assign axi.awid    = w_id;
  assign axi.awlen   = w_len;
  assign axi.awsize  = 3'd3;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wvalid  = (r_state == S_W) ||
                       ((r_state == S_AW) && (r_cnt == 4'd0) && !r_wsent);
  assign axi.wid     = w_id;
  assign axi.wdata   = r_wline[r_cnt[IDXW-1:0]];
  assign axi.wstrb   = r_burst ? 8'hFF : r_wstrb;
  assign axi.wlast   = ((r_state == S_AW) || (r_state == S_W)) && w_cnt_last;
  assign axi.bready  = (r_state == S_B);

  // Client-side handshakes and read-beat routing to the owner
  assign i_ack    = w_grant_i;
  assign d_ack    = w_grant_d;
  assign w_r_i    = (r_state == S_R) && !r_owner_d;
  assign w_r_d    = (r_state == S_R) && r_owner_d;
  assign i_rvalid = w_r_i & axi.rvalid;
  assign i_rdata  = w_r_i ? axi.rdata : 64'd0;
  assign i_rlast  = w_r_i & axi.rvalid & axi.rlast;
  assign d_rvalid = w_r_d & axi.rvalid;
  assign d_rdata  = w_r_d ? axi.rdata : 64'd0;
  assign d_rlast  = w_r_d & axi.rvalid & axi.rlast;
  assign d_wdone  = (r_state == S_B) & axi.bvalid;
  assign bus_err  = ((r_state == S_R) && axi.rvalid && (axi.rresp != 2'b00)) ||
                    ((r_state == S_B) && axi.bvalid && (axi.bresp != 2'b00));

  // Response IDs are deliberately ignored: only one transaction is ever outstanding
  assign w_unused = &{1'b0, axi.rid, axi.bid};

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed bench for axi_cache_bridge: the bench plays the AXI slave by hand.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_axi_cache_bridge;
  localparam int LB = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          i_req, i_burst, i_ack, i_rvalid, i_rlast;
  logic [31:0]   i_addr;
  logic [63:0]   i_rdata;
  logic          d_req, d_we, d_burst, d_ack, d_rvalid, d_rlast, d_wdone, bus_err;
  logic [31:0]   d_addr;
  logic [64*LB-1:0] d_wline;
  logic [7:0]    d_wstrb;
  logic [63:0]   d_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int err_pulses;
  logic [63:0] v;

  axi_cache_bridge_if axi();

  axi_cache_bridge #(.LINE_BEATS(LB), .ID_I(4'd0), .ID_D(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_burst(i_burst), .i_addr(i_addr), .i_ack(i_ack),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_req(d_req), .d_we(d_we), .d_burst(d_burst), .d_addr(d_addr),
    .d_wline(d_wline), .d_wstrb(d_wstrb), .d_ack(d_ack),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
    .d_wdone(d_wdone), .bus_err(bus_err), .axi(axi)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = 64'd0; axi.rresp = 2'b00; axi.rid = 4'd0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'd0;
  endtask

  initial begin
    aresetn = 1'b0; i_req = 1'b0; i_burst = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_burst = 1'b0; d_addr = 32'd0; d_wline = '0; d_wstrb = 8'd0;
    slave_idle();
    repeat (2) @(posedge aclk);

    // ---------------- reset state
    @(negedge aclk); #1;
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_rready", axi.rready, 1'b0);
    chk("rst_bready", axi.bready, 1'b0);
    chk("rst_araddr", axi.araddr, 32'd0);
    chk("rst_arid", axi.arid, 4'd0);
    chk("rst_arlen", axi.arlen, 8'd0);
    chk("rst_wdata", axi.wdata, 64'd0);
    chk("rst_wstrb", axi.wstrb, 8'd0);
    chk("rst_acks", {i_ack, d_ack, d_wdone, bus_err}, 4'b0000);

    // ---------------- I line read
    @(negedge aclk); aresetn = 1'b1; i_req = 1'b1; i_burst = 1'b1; i_addr = 32'h8000_0000; #1;
    chk("t1_i_ack", i_ack, 1'b1);
    chk("t1_arvalid_t", axi.arvalid, 1'b0);
    @(negedge aclk); i_req = 1'b0; #1;
    chk("t1_i_ack_off", i_ack, 1'b0);
    chk("t1_arvalid", axi.arvalid, 1'b1);
    chk("t1_araddr", axi.araddr, 32'h8000_0000);
    chk("t1_arlen", axi.arlen, 8'd3);
    chk("t1_arsize", axi.arsize, 3'd3);
    chk("t1_arburst", axi.arburst, 2'b01);
    chk("t1_arid", axi.arid, 4'd0);
    @(negedge aclk); axi.arready = 1'b1; #1;
    chk("t1_arvalid_hold", axi.arvalid, 1'b1);
    chk("t1_araddr_hold", axi.araddr, 32'h8000_0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      axi.arready = 1'b0;
      v = 64'hC0DE_0000_0000_0000 + 64'(k);
      axi.rvalid = 1'b1; axi.rdata = v; axi.rlast = (k == 3);
      #1;
      chk("t1_rready", axi.rready, 1'b1);
      chk("t1_i_rvalid", i_rvalid, 1'b1);
      chk("t1_i_rdata", i_rdata, v);
      chk("t1_i_rlast", i_rlast, (k == 3));
      chk("t1_d_rvalid", d_rvalid, 1'b0);
    end
    @(negedge aclk); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk("t1_idle_rready", axi.rready, 1'b0);
    chk("t1_idle_arvalid", axi.arvalid, 1'b0);

    // ---------------- D single write
    @(negedge aclk);
    d_req = 1'b1; d_we = 1'b1; d_burst = 1'b0; d_addr = 32'h8000_0010; d_wstrb = 8'h0F;
    d_wline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_2222_3333_4444};
    #1;
    chk("t2_d_ack", d_ack, 1'b1);
    chk("t2_i_ack", i_ack, 1'b0);
    @(negedge aclk); d_req = 1'b0; #1;
    chk("t2_awvalid", axi.awvalid, 1'b1);
    chk("t2_wvalid", axi.wvalid, 1'b1);
    chk("t2_awaddr", axi.awaddr, 32'h8000_0010);
    chk("t2_awlen", axi.awlen, 8'd0);
    chk("t2_awid", axi.awid, 4'd1);
    chk("t2_wid", axi.wid, 4'd1);
    chk("t2_wlast", axi.wlast, 1'b1);
    chk("t2_wstrb", axi.wstrb, 8'h0F);
    chk("t2_wdata", axi.wdata, 64'h1111_2222_3333_4444);
    @(negedge aclk); axi.awready = 1'b1; axi.wready = 1'b1; #1;
    chk("t2_aw_w_both", {axi.awvalid, axi.wvalid}, 2'b11);
    @(negedge aclk); axi.awready = 1'b0; axi.wready = 1'b0; #1;
    chk("t2_b_bready", axi.bready, 1'b1);
    chk("t2_b_valids", {axi.awvalid, axi.wvalid, d_wdone}, 3'b000);
    @(negedge aclk); axi.bvalid = 1'b1; #1;
    chk("t2_wdone", d_wdone, 1'b1);
    chk("t2_bus_err", bus_err, 1'b0);
    @(negedge aclk); axi.bvalid = 1'b0; #1;
    chk("t2_wdone_off", d_wdone, 1'b0);
    chk("t2_bready_off", axi.bready, 1'b0);

    // ---------------- D line writeback
    @(negedge aclk);
    d_req = 1'b1; d_we = 1'b1; d_burst = 1'b1; d_addr = 32'h8000_0100; d_wstrb = 8'h0F;
    d_wline = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
               64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    #1;
    chk("t3_d_ack", d_ack, 1'b1);
    @(negedge aclk); d_req = 1'b0; axi.wready = 1'b1; #1;
    chk("t3_awvalid", axi.awvalid, 1'b1);
    chk("t3_awlen", axi.awlen, 8'd3);
    chk("t3_wvalid0", axi.wvalid, 1'b1);
    chk("t3_wdata0", axi.wdata, 64'hA0A0_0000_0000_0000);
    chk("t3_wlast0", axi.wlast, 1'b0);
    chk("t3_wstrb0", axi.wstrb, 8'hFF);
    @(negedge aclk); axi.wready = 1'b0; axi.awready = 1'b1; #1;
    chk("t3_aw_wait", {axi.awvalid, axi.wvalid}, 2'b10);
    @(negedge aclk); axi.awready = 1'b0; #1;
    chk("t3_stall_wvalid", axi.wvalid, 1'b1);
    chk("t3_stall_wdata", axi.wdata, 64'hA1A1_0000_0000_0001);
    for (int k = 1; k < 4; k++) begin
      @(negedge aclk); axi.wready = 1'b1; #1;
      v = {8'hA0 + 8'(k), 8'hA0 + 8'(k), 48'(k)};
      chk("t3_wdata", axi.wdata, v);
      chk("t3_wlast", axi.wlast, (k == 3));
      chk("t3_wstrb", axi.wstrb, 8'hFF);
    end
    @(negedge aclk); axi.wready = 1'b0; axi.bvalid = 1'b1; #1;
    chk("t3_wvalid_b", axi.wvalid, 1'b0);
    chk("t3_wdone", d_wdone, 1'b1);
    @(negedge aclk); axi.bvalid = 1'b0; #1;
    chk("t3_wdone_off", d_wdone, 1'b0);

    // ---------------- arbitration from reset: D, I, D, I
    @(negedge aclk); aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1; i_req = 1'b1; d_req = 1'b1; i_burst = 1'b0; d_burst = 1'b0; d_we = 1'b0;
    i_addr = 32'h0000_0200; d_addr = 32'h0000_0100;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("t4_d_ack", d_ack, (n % 2 == 0));
      chk("t4_i_ack", i_ack, (n % 2 == 1));
      @(negedge aclk); axi.arready = 1'b1; #1;
      chk("t4_ack_width", {i_ack, d_ack}, 2'b00);
      chk("t4_arid", axi.arid, (n % 2 == 0) ? 4'd1 : 4'd0);
      chk("t4_araddr", axi.araddr, (n % 2 == 0) ? 32'h100 : 32'h200);
      chk("t4_arlen", axi.arlen, 8'd0);
      @(negedge aclk);
      axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 64'(n);
      #1;
      chk("t4_d_rvalid", d_rvalid, (n % 2 == 0));
      chk("t4_i_rvalid", i_rvalid, (n % 2 == 1));
      @(negedge aclk); axi.rvalid = 1'b0; axi.rlast = 1'b0;
      if (n == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    #1;
    chk("t4_no_ack", {i_ack, d_ack}, 2'b00);

    // ---------------- error response on beat 2
    err_pulses = 0;
    @(negedge aclk); i_req = 1'b1; i_burst = 1'b1; i_addr = 32'h8000_0040; #1;
    chk("t5_i_ack", i_ack, 1'b1);
    @(negedge aclk); i_req = 1'b0; axi.arready = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = (k == 3);
      axi.rresp = (k == 1) ? 2'b10 : 2'b00; axi.rdata = 64'h5500 + 64'(k);
      #1;
      if (bus_err) err_pulses++;
      chk("t5_bus_err", bus_err, (k == 1));
      chk("t5_i_rlast", i_rlast, (k == 3));
    end
    @(negedge aclk); axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; #1;
    chk("t5_bus_err_off", bus_err, 1'b0);
    chk("t5_err_count", 64'(err_pulses), 64'd1);
    chk("t5_idle", axi.rready, 1'b0);

    // ---------------- reset during W after beat 1
    @(negedge aclk);
    d_req = 1'b1; d_we = 1'b1; d_burst = 1'b1; d_addr = 32'h8000_0080;
    d_wline = {64'h6003, 64'h6002, 64'h6001, 64'h6000};
    #1;
    chk("t6_d_ack", d_ack, 1'b1);
    @(negedge aclk); d_req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1; #1;
    chk("t6_wdata0", axi.wdata, 64'h6000);
    @(negedge aclk); axi.awready = 1'b0; #1;
    chk("t6_wdata1", axi.wdata, 64'h6001);
    chk("t6_wvalid1", axi.wvalid, 1'b1);
    @(negedge aclk); axi.wready = 1'b0; axi.bvalid = 1'b1; aresetn = 1'b0; #1;
    chk("t6_wdata2", axi.wdata, 64'h6002);
    @(negedge aclk); #1;
    chk("t6_rst_wvalid", axi.wvalid, 1'b0);
    chk("t6_rst_awvalid", axi.awvalid, 1'b0);
    chk("t6_rst_bready", axi.bready, 1'b0);
    chk("t6_rst_wdone", d_wdone, 1'b0);
    chk("t6_rst_awaddr", axi.awaddr, 32'd0);
    chk("t6_rst_wdata", axi.wdata, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1; axi.bvalid = 1'b0; i_req = 1'b1; i_burst = 1'b0; i_addr = 32'h0000_0300;
    #1;
    chk("t6_idle_i_ack", i_ack, 1'b1);
    chk("t6_idle_d_ack", d_ack, 1'b0);
    @(negedge aclk); i_req = 1'b0; #1;
    chk("t6_arvalid", axi.arvalid, 1'b1);
    chk("t6_araddr", axi.araddr, 32'h0000_0300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
